// File: rtl/tile_pixel_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tile_pixel_fetch
//  Description : Producer side of the pixel-index FIFO. Walks the screen in
//                raster order, reads the tile map RAM and then the tile
//                pattern RAM, and writes one 8-bit palette index per pixel
//                into the pixel FIFO. Honours FIFO-full backpressure and
//                restarts the frame at (0,0) whenever ScreenStop is released.
//  Ports       : MemClk        - clock, registers update on the falling edge
//                Reset         - asynchronous active-low reset
//                ScreenStop    - high = abort and hold idle
//                MAP_rdaddress - tile map read address (row base + tile col)
//                MAP_q         - tile index, one cycle after the address
//                PAT_rdaddress - {tile, fine row, fine col}
//                PAT_q         - palette index, one cycle after the address
//                PIX_data      - pixel index to the FIFO
//                PIX_wrreq     - FIFO write strobe
//                PIX_wrfull    - FIFO full
//                FrameDone     - pulse with the write of the last pixel
//  Revision    : 1.0 - initial release
// ============================================================================
module tile_pixel_fetch #(
    parameter int COLS   = 80,
    parameter int ROWS   = 60,
    parameter int MAP_AW = 13
) (
    input  logic              MemClk,
    input  logic              Reset,
    input  logic              ScreenStop,
    output logic [MAP_AW-1:0] MAP_rdaddress,
    input  logic [7:0]        MAP_q,
    output logic [13:0]       PAT_rdaddress,
    input  logic [7:0]        PAT_q,
    output logic [7:0]        PIX_data,
    output logic              PIX_wrreq,
    input  logic              PIX_wrfull,
    output logic              FrameDone
);

    localparam int X_W  = $clog2(COLS * 8);
    localparam int Y_W  = $clog2(ROWS * 8);
    localparam int TC_W = X_W - 3;

    localparam logic [X_W-1:0]    c_x_max = X_W'(COLS * 8 - 1);
    localparam logic [Y_W-1:0]    c_y_max = Y_W'(ROWS * 8 - 1);
    localparam logic [MAP_AW-1:0] c_cols  = MAP_AW'(COLS);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_map_rd  = 2'd1;
    localparam logic [1:0] c_map_wt  = 2'd2;
    localparam logic [1:0] c_pat_run = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;

    // Position of the next pattern read to issue
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [MAP_AW-1:0] r_row_base;
    logic [7:0]        r_tile;

    // Pattern read in flight (lands in the skid buffer at the next edge)
    logic              r_pend;
    logic              r_pend_last;

    // Two-entry skid buffer; entry 0 is the head presented to the FIFO
    logic [1:0]        r_cnt;
    logic [7:0]        r_dat0;
    logic [7:0]        r_dat1;
    logic              r_lst0;
    logic              r_lst1;

    logic              w_pop;
    logic [1:0]        w_cnt_next;
    logic              w_room;
    logic              w_issue;
    logic              w_tile_ld;
    logic              w_x_last;
    logic              w_y_last;
    logic [MAP_AW-1:0] w_next_row_base;
    logic [TC_W-1:0]   w_next_tcol;

    // Writes are gated by ScreenStop so a stop coinciding with the last pixel
    // produces neither the write nor the FrameDone pulse.
    assign w_pop      = (r_cnt != 2'd0) && !PIX_wrfull && !ScreenStop;
    assign PIX_wrreq  = w_pop;
    assign FrameDone  = w_pop && r_lst0;
    assign PIX_data   = r_dat0;

    // A new read lands one edge after issue, possibly with no pop at that
    // edge, so issue only if the buffer will hold at most one entry after
    // the current edge.
    assign w_cnt_next = r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
    assign w_room     = (w_cnt_next <= 2'd1);

    assign w_x_last   = (r_x == c_x_max);
    assign w_y_last   = (r_y == c_y_max);

    // Row base after the current issue: unchanged within a scanline, steps
    // by COLS after the eighth scanline of a tile row, wraps to 0 at frame end.
    always_comb begin
        w_next_row_base = r_row_base;
        w_next_tcol     = r_x[X_W-1:3] + 1'b1;
        if (w_x_last) begin
            w_next_tcol = '0;
            if (w_y_last) begin
                w_next_row_base = '0;
            end else if (r_y[2:0] == 3'd7) begin
                w_next_row_base = r_row_base + c_cols;
            end
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(negedge MemClk or negedge Reset) begin
        if (!Reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle:    w_state_next = c_map_rd;
            c_map_rd:  w_state_next = c_map_wt;
            c_map_wt:  w_state_next = c_pat_run;
            c_pat_run: if (w_issue && (r_x[2:0] == 3'd7)) w_state_next = c_map_rd;
            default:   w_state_next = c_idle;
        endcase
        if (ScreenStop) begin
            w_state_next = c_idle;
        end
    end

    always_comb begin
        w_issue   = 1'b0;
        w_tile_ld = 1'b0;
        case (r_state)
            c_map_wt:  w_tile_ld = !ScreenStop;
            c_pat_run: w_issue   = w_room && !ScreenStop;
            default: ;
        endcase
    end

    // ------------------------------------------------------ fetch datapath
    always_ff @(negedge MemClk or negedge Reset) begin
        if (!Reset) begin
            r_x           <= '0;
            r_y           <= '0;
            r_row_base    <= '0;
            r_tile        <= '0;
            r_pend        <= 1'b0;
            r_pend_last   <= 1'b0;
            MAP_rdaddress <= '0;
            PAT_rdaddress <= '0;
        end else if (ScreenStop) begin
            r_x           <= '0;
            r_y           <= '0;
            r_row_base    <= '0;
            r_tile        <= '0;
            r_pend        <= 1'b0;
            r_pend_last   <= 1'b0;
            MAP_rdaddress <= '0;
            PAT_rdaddress <= '0;
        end else begin
            r_pend      <= w_issue;
            r_pend_last <= w_issue && w_x_last && w_y_last;
            if (w_tile_ld) begin
                r_tile <= MAP_q;
            end
            if (w_issue) begin
                PAT_rdaddress <= {r_tile, r_y[2:0], r_x[2:0]};
                r_row_base    <= w_next_row_base;
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= w_y_last ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
                // Last fine column: present the next tile's map address so it
                // is stable for the whole MAP_RD/MAP_WT pair.
                if (r_x[2:0] == 3'd7) begin
                    MAP_rdaddress <= w_next_row_base + MAP_AW'(w_next_tcol);
                end
            end
        end
    end

    // --------------------------------------------------------- skid buffer
    always_ff @(negedge MemClk or negedge Reset) begin
        if (!Reset) begin
            r_cnt  <= 2'd0;
            r_dat0 <= '0;
            r_dat1 <= '0;
            r_lst0 <= 1'b0;
            r_lst1 <= 1'b0;
        end else if (ScreenStop) begin
            r_cnt  <= 2'd0;
            r_dat0 <= '0;
            r_dat1 <= '0;
            r_lst0 <= 1'b0;
            r_lst1 <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            case ({r_pend, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_dat0 <= PAT_q;
                        r_lst0 <= r_pend_last;
                    end else begin
                        r_dat1 <= PAT_q;
                        r_lst1 <= r_pend_last;
                    end
                end
                2'b01: begin
                    r_dat0 <= r_dat1;
                    r_lst0 <= r_lst1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_dat0 <= PAT_q;
                        r_lst0 <= r_pend_last;
                    end else begin
                        r_dat0 <= r_dat1;
                        r_lst0 <= r_lst1;
                        r_dat1 <= PAT_q;
                        r_lst1 <= r_pend_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tile_pixel_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tile_pixel_fetch
//  Description : Self-checking bench for tile_pixel_fetch on a 4x2-tile
//                screen. Map and pattern RAMs are modelled with one cycle of
//                read latency; expected pixels are queued when a run is
//                started and popped on every FIFO write.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_pixel_fetch;

    localparam int COLS    = 4;
    localparam int ROWS    = 2;
    localparam int MAP_AW  = 13;
    localparam int C_LINE  = COLS * 8;
    localparam int C_FRAME = COLS * 8 * ROWS * 8;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              stop  = 1'b0;
    logic              full  = 1'b0;
    logic [MAP_AW-1:0] map_addr;
    logic [7:0]        map_q;
    logic [13:0]       pat_addr;
    logic [7:0]        pat_q;
    logic [7:0]        data;
    logic              wrreq;
    logic              done;

    tile_pixel_fetch #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .MAP_AW (MAP_AW)
    ) u_dut (
        .MemClk        (clk),
        .Reset         (rst_n),
        .ScreenStop    (stop),
        .MAP_rdaddress (map_addr),
        .MAP_q         (map_q),
        .PAT_rdaddress (pat_addr),
        .PAT_q         (pat_q),
        .PIX_data      (data),
        .PIX_wrreq     (wrreq),
        .PIX_wrfull    (full),
        .FrameDone     (done)
    );

    always #5 clk = ~clk;

    // RAM models: address changes on the falling edge, data captured on the
    // rising edge, so it is valid at the following falling edge.
    logic [7:0] map_mem [0:8191];
    logic [7:0] pat_mem [0:16383];

    initial begin
        for (int a = 0; a < 8192; a++) map_mem[a] = 8'(a + 1);
        for (int a = 0; a < 16384; a++) begin
            logic [13:0] av;
            av         = 14'(a);
            pat_mem[a] = {av[9:6], av[3], av[2:0]};
        end
    end

    always @(posedge clk) begin
        map_q <= map_mem[map_addr];
        pat_q <= pat_mem[pat_addr];
    end

    // ------------------------------------------------------------ checking
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pixel n of a frame, straight from the screen/tile definition
    function automatic logic [7:0] ref_pix(input int n);
        int x, y, a;
        logic [7:0] t;
        logic [2:0] fx;
        logic       fy;
        x  = n % C_LINE;
        y  = n / C_LINE;
        a  = (y / 8) * COLS + (x / 8);
        t  = 8'(a + 1);
        fx = 3'(x % 8);
        fy = 1'(y % 2);
        return {t[3:0], fy, fx};
    endfunction

    typedef struct packed {
        logic [7:0] pix;
        logic       last;
    } exp_t;

    exp_t sb_q[$];

    task automatic push_exp(input int first, input int count);
        for (int i = 0; i < count; i++) begin
            exp_t e;
            int   n;
            n      = (first + i) % C_FRAME;
            e.pix  = ref_pix(n);
            e.last = (n == C_FRAME - 1);
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_size(input string tag, input int target, input int budget);
        int k;
        k = 0;
        while (sb_q.size() > target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(sb_q.size()), 32'(target));
    endtask

    // ------------------------------------------------------------- monitor
    int   cyc      = 0;
    int   prev_cyc = 0;
    int   line_cyc = 0;
    int   thr_idx  = 0;
    logic thr_en   = 1'b0;

    always @(posedge clk) begin : mon
        exp_t e;
        cyc = cyc + 1;
        if (full) check("wrreq_while_full", 32'(wrreq), 0);
        if (wrreq) begin
            check("scoreboard_has_entry", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("pix_data", 32'(data), 32'(e.pix));
                check("frame_done", 32'(done), 32'(e.last));
            end
            if (thr_en) begin
                if (thr_idx % 8 != 0) check("gap_in_tile", 32'(cyc - prev_cyc), 1);
                if (thr_idx % C_LINE == 0) begin
                    if (thr_idx > 0) check("line_idle_le8", 32'((cyc - line_cyc - C_LINE) <= 8), 1);
                    line_cyc = cyc;
                end
                prev_cyc = cyc;
                thr_idx++;
            end
        end else begin
            check("done_without_write", 32'(done), 0);
        end
    end

    // ------------------------------------------------------------ stimulus
    initial begin : main
        int k;

        repeat (3) @(negedge clk);
        #1;
        check("rst_wrreq", 32'(wrreq), 0);
        check("rst_done", 32'(done), 0);
        check("rst_data", 32'(data), 0);
        check("rst_map_addr", 32'(map_addr), 0);
        check("rst_pat_addr", 32'(pat_addr), 0);

        // Free run: two frames plus the first pixel of the third
        push_exp(0, 2 * C_FRAME + 1);
        thr_en = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b1;
        wait_size("free_run_drained", 0, 4000);
        #1 stop = 1'b1;
        thr_en = 1'b0;
        repeat (3) @(negedge clk);

        // Random backpressure over two frames
        push_exp(0, 2 * C_FRAME);
        #1 stop = 1'b0;
        for (k = 0; k < 8000; k++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
            #1 full = 1'($urandom_range(0, 1));
        end
        #1 full = 1'b0;
        stop = 1'b1;
        check("random_full_drained", 32'(sb_q.size()), 0);
        repeat (3) @(negedge clk);

        // Long stall with pixel 5 at the head
        push_exp(0, 16);
        #1 stop = 1'b0;
        wait_size("stall_entry", 11, 100);
        #1 full = 1'b1;
        repeat (20) begin
            @(posedge clk);
            check("stall_data_held", 32'(data), 32'(ref_pix(5)));
        end
        @(negedge clk);
        #1 full = 1'b0;
        @(posedge clk);
        check("stall_release_wrreq", 32'(wrreq), 1);
        check("stall_release_data", 32'(data), 32'(ref_pix(5)));
        wait_size("stall_drained", 0, 200);
        #1 stop = 1'b1;
        repeat (3) @(negedge clk);

        // ScreenStop right after pixel 100, then restart from (0,0)
        push_exp(0, 101);
        #1 stop = 1'b0;
        wait_size("pre_stop_drained", 0, 400);
        #1 stop = 1'b1;
        repeat (5) begin
            @(posedge clk);
            check("stop_hold_wrreq", 32'(wrreq), 0);
        end
        @(negedge clk);
        push_exp(0, 20);
        #1 stop = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(posedge clk);
            if (wrreq) break;
        end
        check("restart_first_pix", 32'(data), 32'h10);
        wait_size("restart_drained", 0, 200);
        #1 stop = 1'b1;
        repeat (3) @(negedge clk);

        // ScreenStop exactly when the last pixel of the frame is due
        push_exp(0, C_FRAME - 1);
        #1 stop = 1'b0;
        wait_size("pre_last_drained", 0, 1200);
        #1 stop = 1'b1;
        repeat (2) begin
            @(posedge clk);
            check("stop_vs_last_wrreq", 32'(wrreq), 0);
            check("stop_vs_last_done", 32'(done), 0);
        end
        @(negedge clk);

        // Asynchronous reset mid-tile
        push_exp(0, 40);
        #1 stop = 1'b0;
        wait_size("pre_reset_progress", 30, 200);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_wrreq", 32'(wrreq), 0);
        check("async_rst_done", 32'(done), 0);
        check("async_rst_data", 32'(data), 0);
        check("async_rst_map_addr", 32'(map_addr), 0);
        check("async_rst_pat_addr", 32'(pat_addr), 0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        push_exp(0, 40);
        #1 rst_n = 1'b1;
        wait_size("after_reset_drained", 0, 200);
        #1 stop = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
